nw_fill_controller: RTL and testbench

Sequencer for the Score_manager score-RAM datapath in the Needleman-Wunsch accelerator. On `start` it initialises row/column 0 with gap penalties. It then walks every cell (i,j) row-major, reading diag/up/left neighbours and computing the cell score and traceback direction. It writes each result back through the insertion port and pulses `done` when the (N,N) cell is written.

---
 rtl/nw_pkg.sv | 38 +++
 rtl/nw_max3.sv | 29 ++
 rtl/nw_fill_controller.sv | 250 +++++++++++++++++++++++++
 tb/tb_nw_fill_controller.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nw_pkg.sv
// Shared definitions for the Needleman-Wunsch score-matrix fill path:
// score width, traceback encodings, FSM states and saturating arithmetic.
package nw_pkg;

    localparam int SCORE_W = 9;

    localparam logic [1:0] DIR_DIAG = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_LEFT = 2'b10;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        INIT = 3'd1,
        RD   = 3'd2,
        CALC = 3'd3,
        WR   = 3'd4,
        NEXT = 3'd5,
        DONE = 3'd6,
        ERR  = 3'd7
    } state_e;

    // Two's complement add evaluated one bit wider, then clamped to
    // [-2^(SCORE_W-1), 2^(SCORE_W-1)-1] so large negative scores never wrap.
    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                    input logic [SCORE_W-1:0] b);
        logic [SCORE_W:0]   sum;
        logic [SCORE_W-1:0] res;
        sum = {a[SCORE_W-1], a} + {b[SCORE_W-1], b};
        if (sum[SCORE_W] != sum[SCORE_W-1]) begin
            res = sum[SCORE_W] ? {1'b1, {(SCORE_W-1){1'b0}}}
                               : {1'b0, {(SCORE_W-1){1'b1}}};
        end else begin
            res = sum[SCORE_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/nw_max3.sv
// Combinational three-way signed maximum with traceback direction.
// Shared between the fill controller and the traceback unit.
// Tie priority: diag over up over left.
module nw_max3
    import nw_pkg::*;
(
    input  logic [SCORE_W-1:0] d_i,
    input  logic [SCORE_W-1:0] u_i,
    input  logic [SCORE_W-1:0] l_i,
    output logic [SCORE_W-1:0] max_o,
    output logic [1:0]         dir_o
);

    // Diag wins unless strictly beaten; then up wins unless left is strictly larger.
    always_comb begin
        max_o = d_i;
        dir_o = DIR_DIAG;
        if (!(($signed(d_i) >= $signed(u_i)) && ($signed(d_i) >= $signed(l_i)))) begin
            if ($signed(u_i) >= $signed(l_i)) begin
                max_o = u_i;
                dir_o = DIR_UP;
            end else begin
                max_o = l_i;
                dir_o = DIR_LEFT;
            end
        end
    end

endmodule

// File: rtl/nw_fill_controller.sv
// Sequencer for the Score_manager score RAM: writes the gap-penalty border,
// then walks every interior cell row-major (read neighbours, score, write
// back), with a bounded wait on each RAM handshake.
//
// Handshake: en_read is held until the RAM answers with signal=1, at which
// point diag/up/left are valid and latched in that same cycle; en_ins/we are
// held until hit=1 acknowledges the write. signal/hit are ignored in every
// other state. A wait longer than TIMEOUT cycles aborts the fill via ERR.
module nw_fill_controller
    import nw_pkg::*;
#(
    parameter int N        = 5,
    parameter int BitAddr  = $clog2(N),
    parameter int MATCH    = 1,
    parameter int MISMATCH = -1,
    parameter int GAP      = -2,
    parameter int TIMEOUT  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               match,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic               en_init,
    output logic               en_read,
    output logic               en_ins,
    output logic               we,
    output logic [BitAddr:0]   addr_init,
    output logic [SCORE_W-1:0] data_init,
    output logic [BitAddr:0]   i,
    output logic [BitAddr:0]   j,
    input  logic               signal,
    input  logic               hit,
    input  logic [SCORE_W-1:0] diag,
    input  logic [SCORE_W-1:0] up,
    input  logic [SCORE_W-1:0] left,
    output logic [SCORE_W-1:0] max,
    output logic [1:0]         dir,
    output logic               dir_valid,
    output logic [2:0]         dbg_state
);

    localparam int IDX_W  = BitAddr + 1;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0]   IDX_N      = IDX_W'(N);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(N - 1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(TIMEOUT - 1);
    localparam logic [SCORE_W-1:0] MATCH_S    = SCORE_W'(MATCH);
    localparam logic [SCORE_W-1:0] MISMATCH_S = SCORE_W'(MISMATCH);
    localparam logic [SCORE_W-1:0] GAP_S      = SCORE_W'(GAP);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   addr_q, addr_d;
    logic [SCORE_W-1:0] data_q, data_d;
    logic [IDX_W-1:0]   i_q, i_d;
    logic [IDX_W-1:0]   j_q, j_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [SCORE_W-1:0] diag_q, diag_d;
    logic [SCORE_W-1:0] up_q, up_d;
    logic [SCORE_W-1:0] left_q, left_d;
    logic [SCORE_W-1:0] max_q, max_d;
    logic [1:0]         dir_q, dir_d;
    logic               error_q, error_d;

    logic busy_q, busy_d;
    logic done_q, done_d;
    logic en_init_q, en_init_d;
    logic en_read_q, en_read_d;
    logic en_ins_q, en_ins_d;
    logic we_q, we_d;
    logic dir_valid_q, dir_valid_d;

    logic [SCORE_W-1:0] cand_d, cand_u, cand_l;
    logic [SCORE_W-1:0] best_max;
    logic [1:0]         best_dir;

    // Candidate scores from the latched neighbours; match only matters in CALC.
    assign cand_d = sat_add(diag_q, match ? MATCH_S : MISMATCH_S);
    assign cand_u = sat_add(up_q, GAP_S);
    assign cand_l = sat_add(left_q, GAP_S);

    nw_max3 u_max3 (
        .d_i   (cand_d),
        .u_i   (cand_u),
        .l_i   (cand_l),
        .max_o (best_max),
        .dir_o (best_dir)
    );

    // State and datapath registers, plus the registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            i_q         <= '0;
            j_q         <= '0;
            wait_q      <= '0;
            diag_q      <= '0;
            up_q        <= '0;
            left_q      <= '0;
            max_q       <= '0;
            dir_q       <= '0;
            error_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            en_init_q   <= 1'b0;
            en_read_q   <= 1'b0;
            en_ins_q    <= 1'b0;
            we_q        <= 1'b0;
            dir_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            i_q         <= i_d;
            j_q         <= j_d;
            wait_q      <= wait_d;
            diag_q      <= diag_d;
            up_q        <= up_d;
            left_q      <= left_d;
            max_q       <= max_d;
            dir_q       <= dir_d;
            error_q     <= error_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            en_init_q   <= en_init_d;
            en_read_q   <= en_read_d;
            en_ins_q    <= en_ins_d;
            we_q        <= we_d;
            dir_valid_q <= dir_valid_d;
        end
    end

    // Next state, border-init counter, cell indices, wait timer and score latch.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        i_d     = i_q;
        j_d     = j_q;
        wait_d  = '0;
        diag_d  = diag_q;
        up_d    = up_q;
        left_d  = left_q;
        max_d   = max_q;
        dir_d   = dir_q;
        error_d = error_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    error_d = 1'b0;
                    addr_d  = '0;
                    data_d  = '0;
                    state_d = INIT;
                end
            end
            INIT: begin
                // data tracks addr*GAP incrementally; saturation keeps it at the floor.
                if (addr_q == IDX_N) begin
                    addr_d  = '0;
                    data_d  = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = RD;
                end else begin
                    addr_d = addr_q + 1'b1;
                    data_d = sat_add(data_q, GAP_S);
                end
            end
            RD: begin
                if (signal) begin
                    diag_d  = diag;
                    up_d    = up;
                    left_d  = left;
                    state_d = CALC;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ERR;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            CALC: begin
                max_d   = best_max;
                dir_d   = best_dir;
                state_d = WR;
            end
            WR: begin
                if (hit) begin
                    state_d = NEXT;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ERR;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            NEXT: begin
                if (j_q < IDX_LAST) begin
                    j_d     = j_q + 1'b1;
                    state_d = RD;
                end else if (i_q < IDX_LAST) begin
                    j_d     = '0;
                    i_d     = i_q + 1'b1;
                    state_d = RD;
                end else begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d == ERR) begin
            error_d = 1'b1;
        end
    end

    // Output decode from the state being entered, so every output is a flop.
    always_comb begin
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        en_init_d   = (state_d == INIT);
        en_read_d   = (state_d == RD);
        en_ins_d    = (state_d == WR);
        we_d        = (state_d == INIT) || (state_d == WR);
        dir_valid_d = (state_q == CALC);
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign en_init   = en_init_q;
    assign en_read   = en_read_q;
    assign en_ins    = en_ins_q;
    assign we        = we_q;
    assign addr_init = addr_q;
    assign data_init = data_q;
    assign i         = i_q;
    assign j         = j_q;
    assign max       = max_q;
    assign dir       = dir_q;
    assign dir_valid = dir_valid_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_nw_fill_controller.sv
// Directed bench for nw_fill_controller with N=2: border init, cell scoring
// (ties, saturation, random), full-walk latency, timeout, busy-start and reset.
module tb_nw_fill_controller;
    import nw_pkg::*;

    localparam int N        = 2;
    localparam int MATCH    = 1;
    localparam int MISMATCH = -1;
    localparam int GAP      = -2;
    localparam int TIMEOUT  = 16;

    logic       clk = 1'b0;
    logic       rst, start, match, signal, hit;
    logic [8:0] diag, up, left;
    logic       busy, done, error, en_init, en_read, en_ins, we, dir_valid;
    logic [1:0] addr_init, i, j, dir;
    logic [8:0] data_init, max;
    logic [2:0] dbg_state;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    logic [10:0] exp_q[$];

    nw_fill_controller #(
        .N(N), .MATCH(MATCH), .MISMATCH(MISMATCH), .GAP(GAP), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .match(match),
        .busy(busy), .done(done), .error(error),
        .en_init(en_init), .en_read(en_read), .en_ins(en_ins), .we(we),
        .addr_init(addr_init), .data_init(data_init), .i(i), .j(j),
        .signal(signal), .hit(hit), .diag(diag), .up(up), .left(left),
        .max(max), .dir(dir), .dir_valid(dir_valid), .dbg_state(dbg_state)
    );

    // clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // hard time limit
    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, miscompares=%0d", miscompares);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int clamp9(input int v);
        if (v > 255) return 255;
        if (v < -256) return -256;
        return v;
    endfunction

    // Reference cell score: {max[8:0], dir[1:0]}
    function automatic logic [10:0] model(input logic [8:0] dg, input logic [8:0] u,
                                          input logic [8:0] l, input logic m);
        int sd, su, sl;
        sd = $signed(dg);
        su = $signed(u);
        sl = $signed(l);
        sd = clamp9(sd + (m ? MATCH : MISMATCH));
        su = clamp9(su + GAP);
        sl = clamp9(sl + GAP);
        if (sd >= su && sd >= sl) return {9'(sd), 2'b00};
        if (su >= sl)             return {9'(su), 2'b01};
        return {9'(sl), 2'b10};
    endfunction

    task automatic wait_en_read;
        int n;
        n = 0;
        while (en_read !== 1'b1 && n < 64) begin
            tick;
            n++;
        end
        check("en_read_seen", en_read, 1);
    endtask

    // Expects to be sampling the first INIT cycle.
    task automatic run_init;
        logic [8:0] ed;
        for (int k = 0; k <= N; k++) begin
            ed = 9'(k * GAP);
            check("init_en_init", en_init, 1);
            check("init_we", we, 1);
            check("init_addr", addr_init, k);
            check("init_data", data_init, ed);
            check("init_others", {en_read, en_ins}, 0);
            check("init_busy", busy, 1);
            tick;
        end
    endtask

    // One cell: sd extra RD cycles before signal, hd extra WR cycles before hit.
    task automatic do_cell(input int sd, input int hd, input logic [8:0] dg,
                           input logic [8:0] u, input logic [8:0] l, input logic m,
                           input int ei, input int ej);
        logic [10:0] e;
        wait_en_read;
        check("cell_i", i, ei);
        check("cell_j", j, ej);
        check("cell_excl", {en_init, en_ins}, 0);
        diag = dg; up = u; left = l; match = m;
        exp_q.push_back(model(dg, u, l, m));
        repeat (sd) tick;
        if (sd > 0) check("rd_held", en_read, 1);
        signal = 1'b1;
        tick;
        signal = 1'b0;
        check("calc_en_read", en_read, 0);
        tick;
        check("wr_dir_valid", dir_valid, 1);
        check("wr_en_ins", {en_ins, we}, 2'b11);
        e = exp_q.pop_front();
        check("cell_max", max, e[10:2]);
        check("cell_dir", dir, e[1:0]);
        signal = 1'b1;
        repeat (hd) tick;
        signal = 1'b0;
        if (hd > 0) begin
            check("wr_held", en_ins, 1);
            check("dv_pulse", dir_valid, 0);
            check("max_stable", max, e[10:2]);
        end
        hit = 1'b1;
        tick;
        hit = 1'b0;
        check("next_en_ins", {en_ins, we}, 0);
    endtask

    initial begin
        int t0, cnt;
        logic [8:0] rd, ru, rl;
        rst = 1'b1; start = 1'b0; match = 1'b0; signal = 1'b0; hit = 1'b0;
        diag = '0; up = '0; left = '0;

        // reset state
        repeat (8) tick;
        rst = 1'b0;
        tick;
        check("rst_flags", {busy, done, error, dir_valid}, 0);
        check("rst_enables", {en_init, en_read, en_ins, we}, 0);
        check("rst_init_bus", {addr_init, data_init}, 0);
        check("rst_ij", {i, j}, 0);
        check("rst_max_dir", {max, dir}, 0);
        check("rst_state", dbg_state, IDLE);

        // fill 1: directed scores with delayed handshakes
        start = 1'b1;
        tick;
        start = 1'b0;
        run_init;
        do_cell(2, 2, 9'h000, 9'h1FE, 9'h1FE, 1'b1, 0, 0);
        do_cell(0, 1, 9'h1FF, 9'h000, 9'h000, 1'b0, 0, 1);
        do_cell(1, 0, 9'h1FC, 9'h000, 9'h000, 1'b0, 1, 0);
        do_cell(0, 3, 9'h000, 9'h000, 9'h005, 1'b0, 1, 1);
        tick;
        check("f1_done", {done, busy}, 2'b11);
        tick;
        check("f1_done_pulse", {done, busy}, 0);
        check("f1_ij_hold", {i, j}, 4'b0101);

        // fill 2: best-case handshakes, saturation corners, total latency
        start = 1'b1;
        tick;
        start = 1'b0;
        t0 = cyc;
        run_init;
        do_cell(0, 0, 9'h100, 9'h100, 9'h100, 1'b0, 0, 0);
        do_cell(0, 0, 9'h0FF, 9'h000, 9'h000, 1'b1, 0, 1);
        do_cell(0, 0, 9'h0F0, 9'h0FF, 9'h0FF, 1'b1, 1, 0);
        do_cell(0, 0, 9'h105, 9'h101, 9'h1FF, 1'b0, 1, 1);
        tick;
        check("f2_done", done, 1);
        check("f2_latency", cyc - t0 + 1, 1 + (N + 1) + 4 * N * N);
        tick;
        check("f2_busy_fall", {done, busy}, 0);

        // fill 3: random neighbours and handshake delays
        start = 1'b1;
        tick;
        start = 1'b0;
        run_init;
        for (int c = 0; c < N * N; c++) begin
            rd = 9'($urandom_range(0, 511));
            ru = 9'($urandom_range(0, 511));
            rl = 9'($urandom_range(0, 511));
            do_cell($urandom_range(0, 3), $urandom_range(0, 3), rd, ru, rl,
                    1'($urandom_range(0, 1)), c / N, c % N);
        end
        tick;
        check("f3_done", done, 1);

        // fill 4: signal never arrives
        tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        run_init;
        wait_en_read;
        cnt = 0;
        while (en_read === 1'b1 && cnt < 40) begin
            cnt++;
            tick;
        end
        check("to_rd_cycles", cnt, TIMEOUT);
        check("to_error", error, 1);
        check("to_enables", {en_init, en_read, en_ins, we}, 0);
        check("to_state_err", dbg_state, ERR);
        tick;
        check("to_idle", {busy, dbg_state}, {1'b0, IDLE});
        check("to_sticky", error, 1);
        tick;
        check("to_sticky2", error, 1);
        start = 1'b1;
        tick;
        start = 1'b0;
        check("to_err_clear", {error, busy}, 2'b01);

        // fill 5: start while busy, then reset during a write
        run_init;
        wait_en_read;
        start = 1'b1;
        tick;
        start = 1'b0;
        check("busy_start_rd", {en_read, en_init, busy}, 3'b101);
        check("busy_start_ij", {i, j}, 0);
        do_cell(0, 0, 9'h003, 9'h001, 9'h002, 1'b1, 0, 0);
        wait_en_read;
        check("pre_rst_j", j, 1);
        signal = 1'b1;
        tick;
        signal = 1'b0;
        tick;
        check("pre_rst_wr", en_ins, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("mid_rst_enables", {en_init, en_read, en_ins, we}, 0);
        check("mid_rst_flags", {busy, done, error, dir_valid}, 0);
        check("mid_rst_state", dbg_state, IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
